// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    // Upper bound on 2*WIDTH for the shared negate helper.
    localparam int MAXW = 128;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic [MAXW-1:0] cneg(
        input logic [MAXW-1:0] v,
        input logic            neg
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers with shift-add multiply and restoring divide.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             fix_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               negr_q, negr_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     hi_sum, rem_sh, diff;
    logic               fits;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quo, rem;

    assign signed_op = ~op_i[0];
    assign a_neg     = signed_op & a_i[WIDTH-1];
    assign b_neg     = signed_op & b_i[WIDTH-1];
    assign a_mag     = a_neg ? -a_i : a_i;
    assign b_mag     = b_neg ? -b_i : b_i;

    // Carry out of the upper half is kept and shifted back in.
    assign hi_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {hi_sum, acc_q[WIDTH-1:1]};

    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff     = rem_sh - {1'b0, opnd_q};
    assign fits     = rem_sh >= {1'b0, opnd_q};
    assign div_next = {fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0],
                       acc_q[WIDTH-2:0], fits};

    always_comb begin
        is_div_d = is_div_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        unique case (1'b1)
            load_i: begin
                is_div_d = op_i[1];
                neg_d    = a_neg ^ b_neg;
                negr_d   = a_neg;
                opnd_d   = op_i[1] ? b_mag : a_mag;
                acc_d    = {{WIDTH{1'b0}}, op_i[1] ? a_mag : b_mag};
            end
            step_i: acc_d = is_div_q ? div_next : mul_next;
            fix_i: begin
                is_div_d = 1'b0;
                neg_d    = 1'b0;
                negr_d   = 1'b0;
                opnd_d   = '0;
                acc_d    = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
        end else begin
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
        end
    end

    assign prod = (2*WIDTH)'(cneg(MAXW'(acc_q), neg_q));
    assign quo  = WIDTH'(cneg(MAXW'(acc_q[WIDTH-1:0]), neg_q));
    assign rem  = WIDTH'(cneg(MAXW'(acc_q[2*WIDTH-1:WIDTH]), negr_q));

    assign hi_o = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
    assign lo_o = is_div_q ? quo : prod[WIDTH-1:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle mult/div controller: FSM, iteration counter, HI/LO and stall.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_e,
    input  logic [1:0]       op_e,
    input  logic [WIDTH-1:0] srca_e,
    input  logic [WIDTH-1:0] srcb_e,
    input  logic             hilo_read_d,
    input  logic             muldiv_d,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall_muldiv,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;

    logic             load, step, fix;
    logic [WIDTH-1:0] dp_hi, dp_lo;

    assign load = (state_q == S_IDLE) & start_e;
    assign step = (state_q == S_RUN);
    assign fix  = (state_q == S_FIX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_e) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    dz_d    = op_e[1] & (srcb_e == '0);
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                hi_d    = dp_hi;
                lo_d    = dp_lo;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (load),
        .step_i (step),
        .fix_i  (fix),
        .op_i   (op_e),
        .a_i    (srca_e),
        .b_i    (srcb_e),
        .hi_o   (dp_hi),
        .lo_o   (dp_lo)
    );

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign busy         = (state_q != S_IDLE);
    assign div_zero     = dz_q;
    assign stall_muldiv = (busy | start_e) & (hilo_read_d | muldiv_d);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed scoreboard bench for muldiv_sequencer at WIDTH=32.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_e;
    logic [1:0]   op_e;
    logic [W-1:0] srca_e, srcb_e;
    logic         hilo_read_d, muldiv_d;
    logic [W-1:0] hi, lo;
    logic         busy, stall_muldiv, div_zero;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_e      (start_e),
        .op_e         (op_e),
        .srca_e       (srca_e),
        .srcb_e       (srcb_e),
        .hilo_read_d  (hilo_read_d),
        .muldiv_d     (muldiv_d),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .stall_muldiv (stall_muldiv),
        .div_zero     (div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference results: {hi, lo}
    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        case (op)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = sa * sb;
                return p;
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                return p;
            end
            2'b10: begin
                if (b == 0) return {a, a[31] ? 32'h1 : 32'hFFFF_FFFF};
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (start_e && busy) begin
            n_fail++;
            $error("FAIL protocol: start_e while busy");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic rd, input logic md);
        logic [63:0] e;
        int n, sbad;
        logic dep;
        dep = rd | md;
        exp_q.push_back(model(op, a, b));
        op_e = op; srca_e = a; srcb_e = b;
        hilo_read_d = rd; muldiv_d = md;
        start_e = 1'b1;
        #1;
        chk({tag, ".stall_c0"}, 64'(stall_muldiv), 64'(dep));
        @(posedge clk); #1;
        start_e = 1'b0;
        n = 0; sbad = 0;
        while (busy && n < 200) begin
            if (stall_muldiv !== dep) sbad++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".stall_window"}, 64'(sbad), 64'd0);
        chk({tag, ".latency"}, 64'(n), 64'(W + 1));
        chk({tag, ".stall_release"}, 64'(stall_muldiv), 64'd0);
        e = exp_q.pop_front();
        chk({tag, ".hi"}, 64'(hi), 64'(e[63:32]));
        chk({tag, ".lo"}, 64'(lo), 64'(e[31:0]));
        chk({tag, ".div_zero"}, 64'(div_zero),
            64'(op[1] && (b == 32'h0)));
        hilo_read_d = 1'b0; muldiv_d = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start_e = 1'b0; op_e = 2'b00;
        srca_e = '0; srcb_e = '0;
        hilo_read_d = 1'b0; muldiv_d = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.stall", 64'(stall_muldiv), 64'd0);
        chk("rst.div_zero", 64'(div_zero), 64'd0);
        @(posedge clk); #1;

        run_op("multu7x6", 2'b01, 32'd7, 32'd6, 1'b0, 1'b0);
        run_op("mult-3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        run_op("div-7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op("divu100/0", 2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
        run_op("multu_mflo", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0,
               1'b1, 1'b0);
        run_op("mult_big", 2'b00, 32'h8000_0000, 32'h8000_0000,
               1'b1, 1'b0);
        run_op("div-7/0", 2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b1);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
               1'b0, 1'b1);
        run_op("div25/-4", 2'b10, 32'd25, 32'hFFFF_FFFC, 1'b1, 1'b0);

        op_e = 2'b01; srca_e = 32'd5; srcb_e = 32'd7;
        hilo_read_d = 1'b1; start_e = 1'b1;
        @(posedge clk); #1;
        start_e = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rstrun.busy", 64'(busy), 64'd0);
        chk("rstrun.hi", 64'(hi), 64'd0);
        chk("rstrun.lo", 64'(lo), 64'd0);
        chk("rstrun.stall", 64'(stall_muldiv), 64'd0);
        chk("rstrun.div_zero", 64'(div_zero), 64'd0);
        reset = 1'b0; hilo_read_d = 1'b0;
        @(posedge clk); #1;

        run_op("multu3x3", 2'b01, 32'd3, 32'd3, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
